// File: rtl/rfid_pkg.sv
// Types shared by the RFID transmit modulator and receive-side envelope decoder.
// Holds the sample word definition, transmit FSM states and the ASK level helper.
package rfid_pkg;

    localparam int SAMPLE_W = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Carrier sample for the given half-cycle polarity and magnitude.
    function automatic sample_t ask_level(input logic neg, input sample_t amp);
        return neg ? -amp : amp;
    endfunction

endpackage

// File: rtl/carrier_phase_gen.sv
// Carrier half-cycle counter and sign flop for the ASK modulator.
// State holds the phase of the next sample; restart rewinds to phase 0, positive.
module carrier_phase_gen #(
    parameter int CARRIER_HALF = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic step,
    input  logic restart,
    output logic sign
);

    localparam int PH_W = $clog2(CARRIER_HALF) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_HALF - 1);

    logic [PH_W-1:0] r_cnt;
    logic            r_sign;
    logic [PH_W-1:0] w_base_cnt;
    logic            w_base_sign;

    // A restart on a stepping strobe counts the restarted sample itself.
    always_comb begin
        w_base_cnt  = restart ? '0 : r_cnt;
        w_base_sign = restart ? 1'b0 : r_sign;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt  <= '0;
            r_sign <= 1'b0;
        end else if (step || restart) begin
            if (step && (w_base_cnt == PH_LAST)) begin
                r_cnt  <= '0;
                r_sign <= ~w_base_sign;
            end else if (step) begin
                r_cnt  <= w_base_cnt + 1'b1;
                r_sign <= w_base_sign;
            end else begin
                r_cnt  <= w_base_cnt;
                r_sign <= w_base_sign;
            end
        end
    end

    assign sign = r_sign;

endmodule

// File: rtl/ask_modulator.sv
// On-off-keyed carrier modulator: one bit per SAMPLES_PER_BIT strobes, with a
// single-entry holding register so back-to-back bits stream without gaps.
module ask_modulator
    import rfid_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 64,
    parameter int CARRIER_HALF    = 4,
    parameter int AMP_ONE         = 20000,
    parameter int AMP_ZERO        = 1000
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    sample_en_in,
    input  logic    bit_in,
    input  logic    bit_valid_in,
    output logic    bit_ready_out,
    output sample_t data_out,
    output logic    period_trigger_out,
    output logic    busy_out
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam sample_t AMP1 = sample_t'(AMP_ONE);
    localparam sample_t AMP0 = sample_t'(AMP_ZERO);

    tx_state_t        r_state;
    logic             r_hold_bit;
    logic             r_hold_full;
    logic             r_act_bit;
    logic [CNT_W-1:0] r_sample_cnt;
    sample_t          r_data;
    logic             r_trig;
    logic             r_busy;

    logic    w_start;
    logic    w_boundary;
    logic    w_reload;
    logic    w_flush;
    logic    w_emit;
    logic    w_emit_bit;
    logic    w_phase_sign;
    logic    w_sample_neg;
    sample_t w_level;

    always_comb begin
        w_start      = sample_en_in && (r_state == IDLE) && r_hold_full;
        w_boundary   = sample_en_in && (r_state == SEND) && (r_sample_cnt == LAST_CNT);
        w_reload     = w_boundary && r_hold_full;
        w_flush      = w_boundary && !r_hold_full;
        w_emit       = w_start || (sample_en_in && (r_state == SEND) && !w_flush);
        w_emit_bit   = (w_start || w_reload) ? r_hold_bit : r_act_bit;
        w_sample_neg = w_start ? 1'b0 : w_phase_sign;
        w_level      = ask_level(w_sample_neg, w_emit_bit ? AMP1 : AMP0);
    end

    carrier_phase_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_phase (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .step    (w_emit),
        .restart (w_start),
        .sign    (w_phase_sign)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_hold_bit   <= 1'b0;
            r_hold_full  <= 1'b0;
            r_act_bit    <= 1'b0;
            r_sample_cnt <= '0;
            r_data       <= '0;
            r_trig       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            // Accept and unload are mutually exclusive: accept needs an empty holder.
            if (bit_valid_in && !r_hold_full) begin
                r_hold_bit  <= bit_in;
                r_hold_full <= 1'b1;
            end else if (w_start || w_reload) begin
                r_hold_full <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_act_bit    <= r_hold_bit;
                        r_sample_cnt <= '0;
                        r_data       <= w_level;
                        r_trig       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (w_flush) begin
                        r_data       <= '0;
                        r_trig       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_sample_cnt <= '0;
                        r_state      <= IDLE;
                    end else if (w_reload) begin
                        r_act_bit    <= r_hold_bit;
                        r_sample_cnt <= '0;
                        r_data       <= w_level;
                        r_trig       <= 1'b1;
                    end else if (sample_en_in) begin
                        r_data       <= w_level;
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bit_ready_out      = !r_hold_full;
    assign data_out           = r_data;
    assign period_trigger_out = r_trig;
    assign busy_out           = r_busy;

endmodule

// File: tb/tb_ask_modulator.sv
// Directed bench for ask_modulator: single bit, burst, slow strobe, backpressure
// and mid-frame reset, checked against hand-computed sample tables.
module tb_ask_modulator;
    import rfid_pkg::*;

    localparam int SPB = 8;
    localparam int CH  = 2;
    localparam int A1  = 20000;
    localparam int A0  = 1000;

    logic    clk_in;
    logic    rst_in;
    logic    sample_en_in;
    logic    bit_in;
    logic    bit_valid_in;
    logic    bit_ready_out;
    sample_t data_out;
    logic    period_trigger_out;
    logic    busy_out;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   tx_q[$];
    logic ready_q;
    // Carrier polarity of each sample in a bit for CARRIER_HALF = 2.
    int   sign8[8] = '{1, 1, -1, -1, 1, 1, -1, -1};

    ask_modulator #(
        .SAMPLES_PER_BIT (SPB),
        .CARRIER_HALF    (CH),
        .AMP_ONE         (A1),
        .AMP_ZERO        (A0)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .sample_en_in       (sample_en_in),
        .bit_in             (bit_in),
        .bit_valid_in       (bit_valid_in),
        .bit_ready_out      (bit_ready_out),
        .data_out           (data_out),
        .period_trigger_out (period_trigger_out),
        .busy_out           (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_value(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit source: holds valid while its queue is non-empty, pops on handshake.
    initial begin
        bit_valid_in = 1'b0;
        bit_in       = 1'b0;
        ready_q      = 1'b1;
        forever begin
            @(posedge clk_in);
            if (bit_valid_in && ready_q && !rst_in && tx_q.size() > 0)
                void'(tx_q.pop_front());
            #1;
            if (tx_q.size() > 0) begin
                bit_valid_in = 1'b1;
                bit_in       = tx_q[0];
            end else begin
                bit_valid_in = 1'b0;
                bit_in       = 1'b0;
            end
            @(negedge clk_in);
            ready_q = bit_ready_out;
        end
    end

    task automatic wait_loaded(input string name);
        bit loaded;
        loaded = 1'b0;
        for (int c = 0; c < 10 && !loaded; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (bit_ready_out === 1'b0) loaded = 1'b1;
        end
        check_value({name, "_load"}, loaded, 1);
    endtask

    task automatic run_frame(input string name, input logic [7:0] bits, input int k,
                             input int per, input int hold);
        int   j;
        int   ph;
        int   limit;
        int   amp;
        int   exp_data;
        int   exp_busy;
        logic was_en;
        int   prev;
        bit   done;
        for (int i = 0; i < k; i++) tx_q.push_back(bits[i]);
        sample_en_in = 1'b0;
        wait_loaded(name);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_value({name, "_bp_ready"}, bit_ready_out, 0);
            check_value({name, "_bp_busy"}, busy_out, 0);
            check_value({name, "_bp_data"}, data_out, 0);
        end
        j     = -1;
        ph    = 0;
        prev  = 0;
        done  = 1'b0;
        limit = (k * SPB + 2) * per + 10;
        for (int c = 0; c < limit && !done; c++) begin
            was_en       = (ph == 0);
            sample_en_in = was_en;
            ph           = (ph + 1) % per;
            @(posedge clk_in);
            @(negedge clk_in);
            if (!was_en) begin
                check_value({name, "_gap_trig"}, period_trigger_out, 0);
                check_value({name, "_gap_hold"}, data_out, prev);
            end else if (j < 0 && period_trigger_out !== 1'b1) begin
                check_value({name, "_pre_data"}, data_out, 0);
                check_value({name, "_pre_busy"}, busy_out, 0);
            end else begin
                j++;
                if (j == k * SPB) begin
                    exp_data = 0;
                    exp_busy = 0;
                    done     = 1'b1;
                end else begin
                    amp      = bits[j / SPB] ? A1 : A0;
                    exp_data = sign8[j % SPB] * amp;
                    exp_busy = 1;
                end
                check_value({name, "_data"}, data_out, exp_data);
                check_value({name, "_trig"}, period_trigger_out, ((j % SPB) == 0) ? 1 : 0);
                check_value({name, "_busy"}, busy_out, exp_busy);
                prev = exp_data;
            end
        end
        check_value({name, "_flush_seen"}, done, 1);
        sample_en_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check_value({name, "_post_trig"}, period_trigger_out, 0);
        check_value({name, "_post_data"}, data_out, 0);
        check_value({name, "_post_busy"}, busy_out, 0);
        check_value({name, "_post_ready"}, bit_ready_out, 1);
        check_value({name, "_queue_empty"}, tx_q.size(), 0);
        sample_en_in = 1'b0;
        $display("frame %s: %0d bits, strobe every %0d cycles, %0d strobes tracked",
                 name, k, per, j + 1);
    endtask

    initial begin
        bit started;
        rst_in       = 1'b0;
        sample_en_in = 1'b0;

        // Asynchronous reset before the first clock edge.
        #2 rst_in = 1'b1;
        #1;
        check_value("rst_data", data_out, 0);
        check_value("rst_trig", period_trigger_out, 0);
        check_value("rst_busy", busy_out, 0);
        check_value("rst_ready", bit_ready_out, 1);
        $display("reset: applied before first edge");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        run_frame("single_1", 8'b0000_0001, 1, 1, 0);
        run_frame("burst_101", 8'b0000_0101, 3, 1, 0);
        run_frame("every4_1", 8'b0000_0001, 1, 4, 0);
        run_frame("bp_1101", 8'b0000_1011, 4, 1, 3);

        // Abort a frame at its 5th sample.
        tx_q.push_back(1'b1);
        wait_loaded("midrst");
        sample_en_in = 1'b1;
        started      = 1'b0;
        for (int c = 0; c < 10 && !started; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (period_trigger_out === 1'b1) started = 1'b1;
        end
        check_value("midrst_start", started, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
        check_value("midrst_s5", data_out, 20000);
        #2 rst_in = 1'b1;
        #1;
        check_value("midrst_data", data_out, 0);
        check_value("midrst_trig", period_trigger_out, 0);
        check_value("midrst_busy", busy_out, 0);
        check_value("midrst_ready", bit_ready_out, 1);
        @(posedge clk_in);
        @(negedge clk_in);
        check_value("midrst_hold_data", data_out, 0);
        check_value("midrst_hold_busy", busy_out, 0);
        rst_in       = 1'b0;
        sample_en_in = 1'b0;
        $display("reset: asserted at sample 5 of a 1 bit");

        run_frame("after_rst_0", 8'b0000_0000, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ask_modulator.md
# ask_modulator

- Transmit-side counterpart of the RFID envelope decoder: takes a stream of data bits and produces signed 32-bit on-off-keyed (ASK) carrier samples.
- Each bit lasts a fixed number of sample strobes and emits a period-boundary trigger.
- Sits between the bit source (framing/command logic) and the DAC/sample sink.
- Its output can be looped directly into the receive chain: decoder input plus period trigger.

## Interface
Parameters:
- SAMPLES_PER_BIT, default 64: sample strobes per bit period; must be ≥ 2.
- CARRIER_HALF, default 4: sample strobes per carrier half-cycle; must be ≥ 1.
- AMP_ONE, default 20000: carrier magnitude for a 1 bit; 0 < AMP_ONE ≤ 2^31−1.
- AMP_ZERO, default 1000: carrier magnitude for a 0 bit; 0 ≤ AMP_ZERO < AMP_ONE.

Ports:
- clk_in  input  1  single system clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- sample_en_in  input  1  sample strobe; all sample-rate state advances only on cycles where it is high.
- bit_in  input  1  data bit to transmit.
- bit_valid_in  input  1  bit_in is valid.
- bit_ready_out  output  1  holding register empty; transfer occurs when valid and ready are both high on a clock edge.
- data_out  output  32 (signed)  modulated carrier sample, registered.
- period_trigger_out  output  1  one-clock pulse marking a bit-period boundary, registered.
- busy_out  output  1  high while in SEND.

## Operation
- Two storage stages:
  - Holding register: hold_bit plus hold_full.
  - Active register: act_bit.
- bit_ready_out = !hold_full, driven from the register only. There is no combinational path from valid to ready. A bit is not accepted on the same cycle the holding register is being unloaded.
- FSM states IDLE and SEND.
- IDLE:
  - data_out = 0, busy_out = 0.
  - On a cycle with sample_en_in && hold_full:
    - move hold_bit to act_bit and clear hold_full;
    - reset the carrier phase (phase count 0, sign positive);
    - sample_cnt = 0;
    - emit the first sample;
    - pulse period_trigger_out;
    - go to SEND.
- SEND, on each sample_en_in:
  - data_out = sign ? −amp : +amp, where amp = act_bit ? AMP_ONE : AMP_ZERO.
  - Advance the carrier phase.
  - If sample_cnt == SAMPLES_PER_BIT−1 (last sample already issued), handle the bit boundary:
    - hold_full: load the next bit and set sample_cnt = 0. This strobe emits the new bit's first sample and pulses period_trigger_out. The carrier phase continues without reset.
    - !hold_full: data_out = 0, pulse period_trigger_out (flush pulse for the decoder), go to IDLE.
  - Otherwise sample_cnt increments.
- Carrier phase:
  - Phase counter runs 0..CARRIER_HALF−1.
  - Sign toggles when the counter wraps.
  - The first sample after IDLE is positive.
- Arithmetic:
  - Negation is done on 32-bit signed values; the parameter range guarantees no overflow.
  - sample_cnt width is $clog2(SAMPLES_PER_BIT).
  - Phase count width is $clog2(CARRIER_HALF)+1.
- Inputs are ignored while rst_in is high.

## Timing
- Reset values, applied asynchronously:
  - data_out = 0, period_trigger_out = 0, busy_out = 0, bit_ready_out = 1;
  - FSM = IDLE, all counters 0, phase sign positive;
  - both bit registers empty.
- Reset mid-bit: outputs go to the reset values immediately. Held and active bits are discarded. The next accepted bit starts a fresh frame with positive phase.
- Latency: a bit accepted at edge N with sample_en_in high at cycle N+1 produces its first sample visible after edge N+1.
- Outputs hold their values between strobes.
- period_trigger_out is high for exactly one clk_in cycle per boundary, never longer, even if sample_en_in is continuously high.
- Burst of K back-to-back bits:
  - K+1 trigger pulses: one at each bit start plus the flush pulse.
  - K·SAMPLES_PER_BIT nonzero samples with no gap.
- Simultaneous accept and unload on one edge cannot occur because ready is registered. A bit offered during the unload edge is accepted on the next edge.

## Structure
- Shared package rfid_pkg holds:
  - SAMPLE_W = 32 and the signed sample typedef;
  - the tx_state_t enum {IDLE, SEND}.
- The receive-side decoder imports the same sample typedef.
- One sub-module: carrier_phase_gen.
  - Contains the phase counter and sign flop.
  - Inputs: clk_in, rst_in, step (sample_en_in && advancing), restart.
  - Output: sign.

## Test plan
Common settings: SAMPLES_PER_BIT=8, CARRIER_HALF=2, AMP_ONE=20000, AMP_ZERO=1000.
- Reset: assert rst_in between edges → data_out 0, trigger 0, busy 0, and bit_ready_out 1 immediately, without waiting for a clock edge.
- Single bit 1, sample_en_in always high:
  - data_out = +20000, +20000, −20000, −20000, +20000, +20000, −20000, −20000;
  - then 0 with a flush trigger;
  - triggers on sample 1 and on the 9th strobe only.
- Bits 1, 0, 1 with valid held:
  - 24 contiguous samples; magnitudes 20000×8, 1000×8, 20000×8;
  - sign pattern continuous across bit boundaries;
  - 4 trigger pulses; busy high throughout.
- sample_en_in every 4th cycle: same sample sequence as the single-bit case; each value held 4 cycles; trigger width exactly 1 cycle.
- Backpressure: valid held with bits 1, 1, 0, 1 while hold_full → ready low; no bit lost or duplicated; output order matches input order.
- Reset asserted at sample 5 of a bit, then release and send 0 → outputs zero at once; new frame starts at +1000 with a single start trigger.
